// File: rtl/bf_pkg.sv
// bf_pkg -- definitions shared across the bfX core.
//
// Contents:
//   OP_LBR / OP_RBR          ASCII opcodes for '[' and ']'
//   CODE_BASE_DEF / _LAST_DEF default code window [0x0000, 0x00FF]
//   seek_state_e             bracket_seeker FSM encoding, also decoded by the
//                            core's debug tap
package bf_pkg;

  localparam logic [7:0]  OP_LBR        = 8'h5B;  // '['
  localparam logic [7:0]  OP_RBR        = 8'h5D;  // ']'

  localparam logic [15:0] CODE_BASE_DEF = 16'h0000;
  localparam logic [15:0] CODE_LAST_DEF = 16'h00FF;

  typedef enum logic [1:0] {
    SEEK_IDLE   = 2'd0,
    SEEK_ISSUE  = 2'd1,
    SEEK_WAIT   = 2'd2,
    SEEK_FINISH = 2'd3
  } seek_state_e;

endpackage

// File: rtl/bracket_seeker.sv
// bracket_seeker -- loop-matching controller for the bfX core.
//
// Given the PC of a '[' (dir=0, scan forward) or ']' (dir=1, scan backward),
// reads code memory through mem port 1, tracks nesting depth and reports the
// address of the matching bracket, or an error when the scan would leave the
// code window or the depth counter would overflow.
//
// Build option: BRACKET_SEEK_PREFETCH_EN
//   undefined : one ISSUE + one WAIT cycle per byte (match at k -> done @ 2k+1)
//   defined   : ISSUE once, then WAIT issues the next address every cycle while
//               evaluating the previous byte (match at k -> done @ k+2)
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, dir, start_pc  scan request; sampled only in IDLE
//   busy                  high from the cycle after start through the done cycle
//   done, error           one-cycle result pulse; error only together with done
//   match_pc              result address, updated on done and held until the next
//   mem_req, mem_addr     port-1 ownership and address toward the fetch mux
//   mem_data              mem.out1, valid the cycle after mem_addr is presented
//   dbg_state             current FSM state (seek_state_e encoding)
//
// Handshake: start is a level sampled at a rising edge while the FSM is IDLE;
// it is ignored in every other state, including FINISH. There is no back
// pressure on done: the result is a single-cycle pulse the core must take.
module bracket_seeker
  import bf_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] CODE_BASE = CODE_BASE_DEF,
  parameter logic [ADDR_W-1:0] CODE_LAST = CODE_LAST_DEF,
  parameter int                DEPTH_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir,
  input  logic [ADDR_W-1:0] start_pc,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] match_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [1:0]        dbg_state
);

  localparam logic [DEPTH_W-1:0] DEPTH_ONE = 1;
  localparam logic [ADDR_W:0]    ADDR_ONE  = 1;

  seek_state_e         state_q, state_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;          // address whose byte is evaluated in WAIT
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;  // address currently presented to mem
  logic [ADDR_W-1:0]   start_pc_q, start_pc_d;
  logic                dir_q, dir_d;
  logic [ADDR_W-1:0]   match_pc_q, match_pc_d;
  logic                err_q, err_d;
  logic                hold_q, hold_d;          // FINISH entered straight from IDLE

  // Address arithmetic is one bit wider so that stepping below zero or past
  // all-ones lands outside the window instead of wrapping into it.
  function automatic logic [ADDR_W:0] step_addr(input logic [ADDR_W-1:0] a,
                                                input logic              d);
    return d ? ({1'b0, a} - ADDR_ONE) : ({1'b0, a} + ADDR_ONE);
  endfunction

  function automatic logic in_code(input logic [ADDR_W:0] a);
    return (a >= {1'b0, CODE_BASE}) && (a <= {1'b0, CODE_LAST});
  endfunction

  logic [ADDR_W:0] start_step;
  logic [ADDR_W:0] eval_step;
  logic            is_open;
  logic            is_close;

  assign start_step = step_addr(start_pc, dir);
  assign eval_step  = step_addr(addr_q, dir_q);

  // Scanning backward, ']' opens a nesting level and '[' closes one.
  assign is_open  = dir_q ? (mem_data == DATA_W'(OP_RBR)) : (mem_data == DATA_W'(OP_LBR));
  assign is_close = dir_q ? (mem_data == DATA_W'(OP_LBR)) : (mem_data == DATA_W'(OP_RBR));

`ifdef BRACKET_SEEK_PREFETCH_EN
  logic [ADDR_W:0] issue_step;
  assign issue_step = step_addr(mem_addr_q, dir_q);
`endif

  always_comb begin
    state_d    = state_q;
    depth_d    = depth_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    start_pc_d = start_pc_q;
    dir_d      = dir_q;
    match_pc_d = match_pc_q;
    err_d      = err_q;
    hold_d     = hold_q;

    case (state_q)
      SEEK_IDLE: begin
        if (start) begin
          start_pc_d = start_pc;
          dir_d      = dir;
          if (!in_code({1'b0, start_pc}) || !in_code(start_step)) begin
            // Nothing to read: spend one extra busy cycle in FINISH so the
            // result lands in cycle 2, and never present an address.
            state_d = SEEK_FINISH;
            err_d   = 1'b1;
            hold_d  = 1'b1;
          end else begin
            state_d    = SEEK_ISSUE;
            err_d      = 1'b0;
            depth_d    = DEPTH_ONE;
            addr_d     = start_step[ADDR_W-1:0];
            mem_addr_d = start_step[ADDR_W-1:0];
          end
        end
      end

      SEEK_ISSUE: begin
        state_d = SEEK_WAIT;
`ifdef BRACKET_SEEK_PREFETCH_EN
        // Run one address ahead; stop advancing at the window edge.
        if (in_code(issue_step)) mem_addr_d = issue_step[ADDR_W-1:0];
`endif
      end

      SEEK_WAIT: begin
        if (is_open && (depth_q == '1)) begin
          state_d    = SEEK_FINISH;
          err_d      = 1'b1;
          match_pc_d = start_pc_q;
        end else if (is_close && (depth_q == DEPTH_ONE)) begin
          state_d    = SEEK_FINISH;
          err_d      = 1'b0;
          match_pc_d = addr_q;
        end else if (!in_code(eval_step)) begin
          state_d    = SEEK_FINISH;
          err_d      = 1'b1;
          match_pc_d = start_pc_q;
        end else begin
          if (is_open)       depth_d = depth_q + DEPTH_ONE;
          else if (is_close) depth_d = depth_q - DEPTH_ONE;
          addr_d = eval_step[ADDR_W-1:0];
`ifdef BRACKET_SEEK_PREFETCH_EN
          // mem_addr_q already holds eval_step; it is the byte evaluated next.
          if (in_code(issue_step)) mem_addr_d = issue_step[ADDR_W-1:0];
`else
          mem_addr_d = eval_step[ADDR_W-1:0];
          state_d    = SEEK_ISSUE;
`endif
        end
      end

      SEEK_FINISH: begin
        if (hold_q) begin
          hold_d     = 1'b0;
          match_pc_d = start_pc_q;
        end else begin
          state_d = SEEK_IDLE;
        end
      end

      default: state_d = SEEK_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SEEK_IDLE;
      depth_q    <= '0;
      addr_q     <= '0;
      mem_addr_q <= '0;
      start_pc_q <= '0;
      dir_q      <= 1'b0;
      match_pc_q <= '0;
      err_q      <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      depth_q    <= depth_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      start_pc_q <= start_pc_d;
      dir_q      <= dir_d;
      match_pc_q <= match_pc_d;
      err_q      <= err_d;
      hold_q     <= hold_d;
    end
  end

  assign busy      = (state_q != SEEK_IDLE);
  assign mem_req   = busy;
  assign done      = (state_q == SEEK_FINISH) && !hold_q;
  assign error     = done && err_q;
  assign match_pc  = match_pc_q;
  assign mem_addr  = mem_addr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bracket_seeker.sv
// tb_bracket_seeker -- directed bench for bracket_seeker with a synchronous
// code memory, a scan-level reference model and a per-cycle output checker.
module tb_bracket_seeker;
  import bf_pkg::*;

`ifdef BRACKET_SEEK_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif
  localparam int BASE = 0;
  localparam int LAST = 255;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rst;
  logic        start;
  logic        dir;
  logic [15:0] start_pc;
  logic        busy, done, error, mem_req;
  logic [15:0] match_pc, mem_addr;
  logic [7:0]  mem_data;
  logic [1:0]  dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bracket_seeker dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dir      (dir),
    .start_pc (start_pc),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .match_pc (match_pc),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .dbg_state(dbg_state)
  );

  // Code memory: registered read, data valid the cycle after the address.
  logic [7:0] code_mem [0:255];
  always @(posedge clk)
    mem_data <= (mem_addr <= 16'h00FF) ? code_mem[mem_addr[7:0]] : 8'h00;

  int edge_n;
  always @(posedge clk) edge_n <= edge_n + 1;

  // ---------------- scoreboard state ----------------
  int          tests;
  int          fails;
  bit          active;
  bit          exp_err;
  bit          exp_oor;
  int          t0;
  int          exp_lat;
  logic [15:0] exp_q[$];
  logic [15:0] last_match;
  bit          seen_done;
  bit          seen_err;
  logic [15:0] seen_mpc;
  int          seen_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // ---------------- reference model ----------------
  // Walks the code array byte by byte with an integer depth. k counts bytes
  // read; the latency follows from k and the build mode.
  function automatic void model_scan(input int spc, input bit d,
                                     output int mpc, output bit err, output int lat);
    int depth;
    int a;
    int k;
    bit fin;
    logic [7:0] opn;
    logic [7:0] cls;
    opn   = d ? 8'h5D : 8'h5B;
    cls   = d ? 8'h5B : 8'h5D;
    mpc   = spc;
    err   = 1'b1;
    k     = 0;
    depth = 1;
    a     = spc;
    fin   = 1'b0;
    if (spc >= BASE && spc <= LAST) begin
      while (!fin) begin
        a = d ? a - 1 : a + 1;
        if (a < BASE || a > LAST) begin
          fin = 1'b1;
        end else begin
          k++;
          if (code_mem[a] == opn) begin
            if (depth == 255) fin = 1'b1;
            else depth++;
          end else if (code_mem[a] == cls) begin
            depth--;
            if (depth == 0) begin
              mpc = a;
              err = 1'b0;
              fin = 1'b1;
            end
          end
        end
      end
    end
    lat = (k == 0) ? 2 : (PF ? k + 2 : 2 * k + 1);
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int rel;
    bit eb;
    bit ed;
    logic [15:0] m;
    if (rst) begin
      chk("rst_busy",     32'(busy),     32'd0);
      chk("rst_done",     32'(done),     32'd0);
      chk("rst_error",    32'(error),    32'd0);
      chk("rst_mem_req",  32'(mem_req),  32'd0);
      chk("rst_match_pc", 32'(match_pc), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    end else begin
      rel = edge_n - t0 + 1;
      eb  = active && (rel >= 1) && (rel <= exp_lat);
      ed  = active && (rel == exp_lat);
      chk("busy",  32'(busy),  32'(eb));
      chk("done",  32'(done),  32'(ed));
      chk("error", 32'(error), 32'(ed && exp_err));
      if (!(active && exp_oor)) chk("mem_req", 32'(mem_req), 32'(eb));
      if (mem_req) chk("mem_addr_in_code", 32'(mem_addr <= 16'h00FF), 32'd1);
      if (active && exp_oor) chk("no_issue_state", 32'(dbg_state == SEEK_ISSUE), 32'd0);
      if (ed) begin
        m = exp_q.pop_front();
        chk("match_pc", 32'(match_pc), 32'(m));
        last_match = m;
        seen_done  = 1'b1;
        seen_mpc   = match_pc;
        seen_err   = error;
        seen_lat   = rel;
        active     = 1'b0;
      end else begin
        chk("match_pc_hold", 32'(match_pc), 32'(last_match));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) code_mem[i] = 8'h2B;  // '+'
  endtask

  task automatic put(input int b, input string s);
    for (int i = 0; i < s.len(); i++) code_mem[b + i] = s[i];
  endtask

  // glitch: cycle at which an extra start is raised (-1 none, -2 the done cycle)
  // rst_at: cycle at which rst is pulsed (0 none)
  task automatic run_scan(input string name, input int spc, input bit d,
                          input int lit_mpc, input bit lit_err,
                          input int lit_base, input int lit_pf,
                          input int glitch, input int rst_at);
    int mpc;
    int lat;
    int g;
    bit err;
    model_scan(spc, d, mpc, err, lat);
    if (rst_at == 0) begin
      chk({name, "_model_mpc"}, 32'(mpc), 32'(lit_mpc));
      chk({name, "_model_err"}, 32'(err), 32'(lit_err));
      chk({name, "_model_lat"}, 32'(lat), 32'(PF ? lit_pf : lit_base));
    end
    g = (glitch == -2) ? lat : glitch;

    @(posedge clk); #1;
    start     = 1'b1;
    start_pc  = 16'(spc);
    dir       = d;
    t0        = edge_n + 1;
    exp_lat   = lat;
    exp_err   = err;
    exp_oor   = (spc < BASE) || (spc > LAST);
    exp_q.push_back(16'(mpc));
    seen_done = 1'b0;
    active    = 1'b1;

    for (int m = 1; m <= 1200; m++) begin
      @(posedge clk); #1;
      if (m == 1) start = 1'b0;
      if (m == g) begin
        start    = 1'b1;
        start_pc = 16'h0010;
        dir      = ~d;
      end else if (m == g + 1) begin
        start = 1'b0;
      end
      if (m == rst_at) begin
        rst        = 1'b1;
        active     = 1'b0;
        exp_q.delete();
        last_match = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        break;
      end
      if (!active) break;
    end
    start = 1'b0;

    if (rst_at > 0) begin
      chk({name, "_no_done"}, 32'(seen_done), 32'd0);
    end else begin
      chk({name, "_done_seen"}, 32'(seen_done), 32'd1);
      if (seen_done) begin
        chk({name, "_dut_mpc"}, 32'(seen_mpc), 32'(lit_mpc));
        chk({name, "_dut_err"}, 32'(seen_err), 32'(lit_err));
        chk({name, "_dut_lat"}, 32'(seen_lat), 32'(PF ? lit_pf : lit_base));
      end
    end
    if (active) begin
      active = 1'b0;
      exp_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    dir        = 1'b0;
    start_pc   = '0;
    last_match = '0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    clear_mem(); put(16'h00, "[+]");
    run_scan("fwd_simple", 16'h00, 1'b0, 16'h02, 1'b0, 5, 4, -1, 0);

    clear_mem(); put(16'h10, "[[-]>]");
    run_scan("fwd_nest",     16'h10, 1'b0, 16'h15, 1'b0, 11, 7, -1, 0);
    run_scan("bwd_nest",     16'h15, 1'b1, 16'h10, 1'b0, 11, 7, -1, 0);
    run_scan("busy_start",   16'h10, 1'b0, 16'h15, 1'b0, 11, 7,  2, 0);
    run_scan("finish_start", 16'h15, 1'b1, 16'h10, 1'b0, 11, 7, -2, 0);

    clear_mem(); code_mem[254] = 8'h5B; code_mem[255] = 8'h2B;
    run_scan("fwd_edge",  16'hFE,  1'b0, 16'hFE,  1'b1, 3, 3, -1, 0);
    run_scan("oor_start", 16'h100, 1'b0, 16'h100, 1'b1, 2, 2, -1, 0);
    run_scan("last_fwd",  16'hFF,  1'b0, 16'hFF,  1'b1, 2, 2, -1, 0);

    clear_mem();
    run_scan("bwd_edge", 16'h03, 1'b1, 16'h03, 1'b1, 7, 5, -1, 0);
    run_scan("first_bwd", 16'h00, 1'b1, 16'h00, 1'b1, 2, 2, -1, 0);

    for (int i = 0; i < 256; i++) code_mem[i] = 8'h5B;
    run_scan("overflow", 16'h00, 1'b0, 16'h00, 1'b1, 511, 257, -1, 0);

    clear_mem(); code_mem[32] = 8'h5B;
    run_scan("rst_mid", 16'h20, 1'b0, 0, 1'b0, 0, 0, -1, 3);

    clear_mem(); put(16'h00, "[+]");
    run_scan("after_rst", 16'h00, 1'b0, 16'h02, 1'b0, 5, 4, -1, 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: got no end of stimulus, want end before time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
